link_sync_ctrl: RTL

Link-level sequencer for the PHY byte-rate datapath. It sits between the upper layer, the parallel-to-serial transmit path and the serial-to-parallel receive path. It drives COM (0xBC) training symbols until both directions are aligned, then shares the transmit lane between upstream data and COM idle fill. It also gates receive bytes to the upper layer and detects loss of alignment and recovers from it.

---
 rtl/link_sync_ctrl_pkg.sv | 18 +
 rtl/link_sync_ctrl_com_run_counter.sv | 33 +++
 rtl/link_sync_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/link_sync_ctrl_pkg.sv
// Shared PHY link definitions: comma symbol, link state encoding and a
// saturating 8-bit increment used by the link counters.
package link_sync_ctrl_pkg;

  localparam logic [7:0] COM_SYMBOL = 8'hBC;

  typedef enum logic [1:0] {
    ST_DOWN    = 2'd0,
    ST_TRAIN   = 2'd1,
    ST_UP      = 2'd2,
    ST_RECOVER = 2'd3
  } link_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/link_sync_ctrl_com_run_counter.sv
// Saturating run length of consecutive received COM bytes, with a synchronous
// clear and a flag that is high once the run has reached THRESH.
module com_run_counter
  import link_sync_ctrl_pkg::*;
#(
  parameter int unsigned THRESH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_byte_vld,
  input  logic [7:0] i_byte,
  output logic       o_at_thresh
);

  localparam logic [7:0] THRESH_W = 8'(THRESH);

  logic [7:0] r_run;

  // Idle cycles (no valid byte) neither extend nor break the run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run <= 8'd0;
    end else if (i_clear) begin
      r_run <= 8'd0;
    end else if (i_byte_vld) begin
      r_run <= (i_byte == COM_SYMBOL) ? sat_inc8(r_run) : 8'd0;
    end
  end

  assign o_at_thresh = (r_run >= THRESH_W);

endmodule

// File: rtl/link_sync_ctrl.sv
// Link sequencer: trains with COM symbols until both directions align, then
// muxes upstream bytes with COM idle fill and forwards non-COM receive bytes.
module link_sync_ctrl
  import link_sync_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_COUNT      = 4,
  parameter int unsigned TRAIN_TX        = 8,
  parameter int unsigned MAX_GAP         = 64,
  parameter int unsigned RECOVER_TIMEOUT = 128
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       rx_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_req_valid,
  input  logic [7:0] tx_req_data,
  output logic       tx_req_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       rx_out_valid,
  output logic [7:0] rx_out_data,
  output logic       link_up,
  output logic [1:0] link_state,
  output logic [7:0] err_count
);

  localparam logic [7:0] TRAIN_TX_W = 8'(TRAIN_TX);
  localparam logic [7:0] MAX_GAP_W  = 8'(MAX_GAP);
  localparam logic [7:0] REC_TO_W   = 8'(RECOVER_TIMEOUT);

  link_state_e r_state;
  link_state_e w_state_nxt;
  logic [7:0]  r_tx_com_cnt;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  r_rec_cnt;
  logic [7:0]  r_err_count;
  logic        r_tx_req_ready;
  logic        r_link_up;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic        r_rx_out_valid;
  logic [7:0]  r_rx_out_data;

  logic        w_rx_com;
  logic        w_rx_lock;
  logic        w_run_clear;
  logic        w_accept;
  logic [7:0]  w_gap_inc;
  logic [7:0]  w_rec_inc;
  logic        w_gap_hit;
  logic        w_rec_hit;
  logic        w_tx_train_done;
  logic        w_tx_valid_nxt;
  logic [7:0]  w_tx_data_nxt;
  logic        w_rx_fwd;

  assign w_rx_com        = rx_valid && (rx_data == COM_SYMBOL);
  assign w_accept        = tx_req_valid && r_tx_req_ready;
  assign w_gap_inc       = sat_inc8(r_gap_cnt);
  assign w_gap_hit       = !w_rx_com && (w_gap_inc >= MAX_GAP_W);
  assign w_rec_inc       = sat_inc8(r_rec_cnt);
  assign w_rec_hit       = (w_rec_inc >= REC_TO_W);
  assign w_tx_train_done = (r_tx_com_cnt >= TRAIN_TX_W);
  // Holding the run clear outside TRAIN/RECOVER makes it start from zero on entry.
  assign w_run_clear     = (r_state == ST_DOWN) || (r_state == ST_UP);

  com_run_counter #(
    .THRESH (LOCK_COUNT)
  ) u_rx_run (
    .i_clk       (clk_4f),
    .i_rst_n     (reset),
    .i_clear     (w_run_clear),
    .i_byte_vld  (rx_valid),
    .i_byte      (rx_data),
    .o_at_thresh (w_rx_lock)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_tx_valid_nxt = 1'b0;
    w_tx_data_nxt  = 8'h00;
    w_rx_fwd       = 1'b0;
    case (r_state)
      ST_DOWN: begin
        if (rx_active) w_state_nxt = ST_TRAIN;
      end
      ST_TRAIN: begin
        w_tx_valid_nxt = 1'b1;
        w_tx_data_nxt  = COM_SYMBOL;
        if (w_tx_train_done && w_rx_lock) w_state_nxt = ST_UP;
      end
      ST_UP: begin
        w_tx_valid_nxt = 1'b1;
        w_tx_data_nxt  = w_accept ? tx_req_data : COM_SYMBOL;
        w_rx_fwd       = rx_valid && !w_rx_com;
        if (w_gap_hit) w_state_nxt = ST_RECOVER;
      end
      ST_RECOVER: begin
        w_tx_valid_nxt = 1'b1;
        w_tx_data_nxt  = COM_SYMBOL;
        if (w_rx_lock)      w_state_nxt = ST_UP;
        else if (w_rec_hit) w_state_nxt = ST_DOWN;
      end
      default: w_state_nxt = ST_DOWN;
    endcase
    // Losing the receive path overrides every other transition.
    if ((r_state != ST_DOWN) && !rx_active) w_state_nxt = ST_DOWN;
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_DOWN;
      r_tx_com_cnt   <= 8'd0;
      r_gap_cnt      <= 8'd0;
      r_rec_cnt      <= 8'd0;
      r_err_count    <= 8'd0;
      r_tx_req_ready <= 1'b0;
      r_link_up      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_tx_req_ready <= (w_state_nxt == ST_UP);
      r_link_up      <= (w_state_nxt == ST_UP);

      if (r_state == ST_DOWN)       r_tx_com_cnt <= 8'd0;
      else if (r_state == ST_TRAIN) r_tx_com_cnt <= sat_inc8(r_tx_com_cnt);

      if (r_state != ST_UP) r_gap_cnt <= 8'd0;
      else                  r_gap_cnt <= w_rx_com ? 8'd0 : w_gap_inc;

      if (r_state != ST_RECOVER) r_rec_cnt <= 8'd0;
      else                       r_rec_cnt <= w_rec_inc;

      if ((r_state == ST_UP) && (w_state_nxt == ST_RECOVER))
        r_err_count <= sat_inc8(r_err_count);
    end
  end

  // Lane outputs follow the present state one cycle later, so a byte accepted
  // or received in the last UP cycle still leaves on the next cycle.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_tx_valid     <= 1'b0;
      r_tx_data      <= 8'h00;
      r_rx_out_valid <= 1'b0;
      r_rx_out_data  <= 8'h00;
    end else begin
      r_tx_valid     <= w_tx_valid_nxt;
      r_tx_data      <= w_tx_data_nxt;
      r_rx_out_valid <= w_rx_fwd;
      if (w_rx_fwd) r_rx_out_data <= rx_data;
    end
  end

  assign tx_req_ready = r_tx_req_ready;
  assign link_up      = r_link_up;
  assign link_state   = r_state;
  assign err_count    = r_err_count;
  assign tx_valid     = r_tx_valid;
  assign tx_data      = r_tx_data;
  assign rx_out_valid = r_rx_out_valid;
  assign rx_out_data  = r_rx_out_data;

endmodule
